// File: rtl/m1_pkg.sv
// ----------------------------------------------------------------------------
// m1_pkg
// Shared definitions for the Crypto1 byte cipher sequencer:
//   - m1_state_t : sequencer FSM states (IDLE/SHIFT/PAR/OUT)
//   - M1_ENC/M1_DEC : direction encodings for in_dir
//   - m1_odd_par : ISO14443A odd-parity bit of a byte
// ----------------------------------------------------------------------------
package m1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2,
      ST_OUT   = 2'd3
   } m1_state_t;

   localparam logic M1_ENC = 1'b0;
   localparam logic M1_DEC = 1'b1;

   // Odd parity: the bit that makes the total count of ones (byte + bit) odd.
   function automatic logic m1_odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/m1_byte_cipher.sv
// ----------------------------------------------------------------------------
// m1_byte_cipher
// Byte-level sequencer in front of the Crypto1 keystream core. Each accepted
// byte is processed LSB-first over eight cycles, each cycle requesting one core
// step and XORing the data bit with the current keystream bit. One further
// cycle samples the following keystream bit (without stepping) to encrypt or
// decrypt the ISO14443A odd-parity bit. Plaintext bits can optionally be fed
// back into the core LFSR (reader-nonce injection).
//
// Ports
//   sysclk, resetn        clock; asynchronous active-low reset
//   flush                 synchronous abort, back to IDLE, results cleared
//   in_valid/in_ready     input byte handshake
//   in_data/in_par        byte and received encrypted parity (decrypt)
//   in_dir/in_feed        0=encrypt 1=decrypt; feed plaintext into LFSR
//   out_valid/out_ready   result handshake
//   out_data/out_par      result byte and parity
//   out_par_err           decrypt parity check failed
//   ks_in                 core filter output for its current state
//   ks_step/ks_feed       core step request and feedback-injection bit
//   dbg_state             current FSM state (m1_state_t encoding)
//
// Handshakes: a transfer happens on a rising sysclk edge where valid and
// ready are both high. in_ready is high only in IDLE with flush low;
// out_valid is high only in OUT and its payload is stable until the transfer.
// flush outranks both handshakes in the same cycle.
// ----------------------------------------------------------------------------
module m1_byte_cipher
   import m1_pkg::*;
(
   input  logic       sysclk,
   input  logic       resetn,
   input  logic       flush,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_par,
   input  logic       in_dir,
   input  logic       in_feed,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_par,
   output logic       out_par_err,
   input  logic       ks_in,
   output logic       ks_step,
   output logic       ks_feed,
   output logic [1:0] dbg_state
);

   m1_state_t  r_state;
   m1_state_t  w_next_state;

   logic [7:0] r_data;
   logic       r_par_in;
   logic       r_dir;
   logic       r_feed;
   logic [2:0] r_k;

   logic [7:0] r_out_data;
   logic       r_out_par;
   logic       r_out_err;

   logic       w_accept;
   logic       w_data_bit;
   logic       w_plain_bit;
   logic [7:0] w_plain_byte;
   logic       w_op;
   logic       w_dec_par;

   assign w_accept   = in_valid && in_ready;
   assign w_data_bit = r_data[r_k];
   // In decrypt the plaintext is the result bit; in encrypt it is the input.
   assign w_plain_bit = (r_dir == M1_DEC) ? (w_data_bit ^ ks_in) : w_data_bit;
   // By PAR the full result byte is in r_out_data, so the plaintext byte is
   // either the latched input (encrypt) or the decrypted result (decrypt).
   assign w_plain_byte = (r_dir == M1_DEC) ? r_out_data : r_data;
   assign w_op         = m1_odd_par(w_plain_byte);
   assign w_dec_par    = r_par_in ^ ks_in;

   // Next-state and handshake/step outputs.
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      ks_step      = 1'b0;
      ks_feed      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = !flush;
            if (w_accept) w_next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            // Gated by flush so an abort issues no step in its own cycle.
            ks_step = !flush;
            ks_feed = !flush && r_feed && w_plain_bit;
            if (r_k == 3'd7) w_next_state = ST_PAR;
         end
         ST_PAR: begin
            w_next_state = ST_OUT;
         end
         ST_OUT: begin
            out_valid = !flush;
            if (out_ready) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
      if (flush) w_next_state = ST_IDLE;
   end

   always_ff @(posedge sysclk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   // Latched byte context and bit counter.
   always_ff @(posedge sysclk or negedge resetn) begin
      if (!resetn) begin
         r_data   <= 8'd0;
         r_par_in <= 1'b0;
         r_dir    <= M1_ENC;
         r_feed   <= 1'b0;
         r_k      <= 3'd0;
      end else if (w_accept) begin
         r_data   <= in_data;
         r_par_in <= in_par;
         r_dir    <= in_dir;
         r_feed   <= in_feed;
         r_k      <= 3'd0;
      end else if (r_state == ST_SHIFT && !flush) begin
         r_k <= r_k + 3'd1;
      end
   end

   // Result registers: written only in SHIFT and PAR, held in OUT.
   always_ff @(posedge sysclk or negedge resetn) begin
      if (!resetn) begin
         r_out_data <= 8'd0;
         r_out_par  <= 1'b0;
         r_out_err  <= 1'b0;
      end else if (flush) begin
         r_out_data <= 8'd0;
         r_out_par  <= 1'b0;
         r_out_err  <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
         r_out_data[r_k] <= w_data_bit ^ ks_in;
      end else if (r_state == ST_PAR) begin
         // ks_in here is the keystream bit that follows the byte.
         if (r_dir == M1_DEC) begin
            r_out_par <= w_dec_par;
            r_out_err <= (w_dec_par != w_op);
         end else begin
            r_out_par <= w_op ^ ks_in;
            r_out_err <= 1'b0;
         end
      end
   end

   assign out_data    = r_out_data;
   assign out_par     = r_out_par;
   assign out_par_err = r_out_err;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_m1_byte_cipher.sv
module tb_m1_byte_cipher;

   logic       sysclk;
   logic       resetn;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_par;
   logic       in_dir;
   logic       in_feed;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_par;
   logic       out_par_err;
   logic       ks_in;
   logic       ks_step;
   logic       ks_feed;
   logic [1:0] dbg_state;

   int total = 0;
   int bad   = 0;

   // Keystream source standing in for the core: a bit stream advanced by one
   // position on every accepted step.
   logic [255:0] ks_stream = '0;
   logic [7:0]   ks_ptr    = 8'd0;
   int           feed_viol = 0;
   logic [0:0]   act_q[$];
   logic [0:0]   exp_q[$];

   assign ks_in = ks_stream[ks_ptr];

   m1_byte_cipher dut (
      .sysclk      (sysclk),
      .resetn      (resetn),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_par      (in_par),
      .in_dir      (in_dir),
      .in_feed     (in_feed),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_par     (out_par),
      .out_par_err (out_par_err),
      .ks_in       (ks_in),
      .ks_step     (ks_step),
      .ks_feed     (ks_feed),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   always @(posedge sysclk) begin
      if (ks_step) ks_ptr <= ks_ptr + 8'd1;
   end

   always @(negedge sysclk) begin
      if (resetn) begin
         if (ks_step) act_q.push_back(ks_feed);
         if (ks_feed && !ks_step) feed_viol++;
      end
   end

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver + model ----------------
   // Offers one byte, checks it against the reference model, applies `hold`
   // cycles of backpressure, then releases it.
   task automatic run_byte(input logic [7:0] d, input logic p, input logic dir,
                           input logic feed, input int hold,
                           output logic [7:0] a_data, output logic a_par,
                           output logic a_err, output logic [7:0] a_feed);
      logic [7:0] base;
      logic [8:0] ks;
      logic [7:0] exp_data, pt, exp_feed, got_feed;
      logic       op, exp_par, exp_err;
      logic [7:0] sd;
      logic       sp, se;
      int         t, ok;

      @(negedge sysclk);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_data = d; in_par = p; in_dir = dir; in_feed = feed;
      base = ks_ptr;
      act_q.delete();
      for (int i = 0; i < 9; i++) ks[i] = ks_stream[8'(base + 8'(i))];

      // Reference: each data bit XOR its keystream bit; parity uses the 9th bit.
      exp_data = d ^ ks[7:0];
      pt       = dir ? exp_data : d;
      op       = (($countones(pt) % 2) == 0);
      if (dir) begin
         exp_par = p ^ ks[8];
         exp_err = (exp_par != op);
      end else begin
         exp_par = op ^ ks[8];
         exp_err = 1'b0;
      end
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(feed ? pt[i] : 1'b0);

      t = 0;
      do begin
         @(negedge sysclk);
         in_valid = 1'b0;
         t++;
      end while (!out_valid && t < 40);
      chk("out_valid_latency", t, 10);
      chk("out_data", {24'd0, out_data}, {24'd0, exp_data});
      chk("out_par", {31'd0, out_par}, {31'd0, exp_par});
      chk("out_par_err", {31'd0, out_par_err}, {31'd0, exp_err});
      chk("step_count", {24'd0, 8'(ks_ptr - base)}, 32'd8);
      chk("feed_count", act_q.size(), 8);
      got_feed = 8'd0;
      exp_feed = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (i < act_q.size()) got_feed[i] = act_q[i][0];
         exp_feed[i] = exp_q[i][0];
      end
      chk("feed_bits", {24'd0, got_feed}, {24'd0, exp_feed});
      a_data = out_data; a_par = out_par; a_err = out_par_err; a_feed = got_feed;

      if (hold > 0) begin
         sd = out_data; sp = out_par; se = out_par_err;
         ok = 1;
         for (int h = 0; h < hold; h++) begin
            @(negedge sysclk);
            if (out_data !== sd || out_par !== sp || out_par_err !== se ||
                out_valid !== 1'b1 || in_ready !== 1'b0 || ks_step !== 1'b0)
               ok = 0;
         end
         chk("hold_stable", ok, 1);
         chk("hold_no_steps", {24'd0, 8'(ks_ptr - base)}, 32'd8);
      end

      out_ready = 1'b1;
      @(negedge sysclk);
      out_ready = 1'b0;
      chk("released_idle", {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       dir;
      logic       feed;
      logic       ks1;
      int         hold;
      logic [7:0] xd;
      logic       xp;
      logic       xe;
      logic [7:0] xf;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [7:0] a_data, a_feed, base;
      logic       a_par, a_err;
      logic       seen_valid;

      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      in_par = 1'b0; in_dir = 1'b0; in_feed = 1'b0; out_ready = 1'b0;

      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_outputs", {20'd0, out_valid, out_data, out_par, out_par_err, ks_step, ks_feed},
          32'd0);
      repeat (2) @(negedge sysclk);
      resetn = 1'b1;

      // ---------- directed table ----------
      //           d      p     dir   feed  ks1  hold xd     xp    xe    xf
      tbl[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[1] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h01, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'hFF, 1'b0, 1'b0, 8'h00};
      tbl[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'hA5, 1'b1, 1'b0, 8'hA5};
      tbl[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'hA5, 1'b1, 1'b0, 8'h00};
      tbl[5] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'hA5, 1'b0, 1'b1, 8'h00};
      tbl[6] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 0, 8'hA5, 1'b1, 1'b0, 8'h00};
      tbl[7] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 20, 8'hC3, 1'b0, 1'b0, 8'h00};

      for (int v = 0; v < 8; v++) begin
         ks_stream = tbl[v].ks1 ? '1 : '0;
         run_byte(tbl[v].d, tbl[v].p, tbl[v].dir, tbl[v].feed, tbl[v].hold,
                  a_data, a_par, a_err, a_feed);
         chk($sformatf("tbl%0d_data", v), {24'd0, a_data}, {24'd0, tbl[v].xd});
         chk($sformatf("tbl%0d_par", v), {31'd0, a_par}, {31'd0, tbl[v].xp});
         chk($sformatf("tbl%0d_err", v), {31'd0, a_err}, {31'd0, tbl[v].xe});
         chk($sformatf("tbl%0d_feed", v), {24'd0, a_feed}, {24'd0, tbl[v].xf});
      end

      // ---------- randomized against the model ----------
      for (int n = 0; n < 40; n++) begin
         for (int w = 0; w < 8; w++) ks_stream[w*32 +: 32] = $urandom();
         run_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), a_data, a_par, a_err, a_feed);
      end

      // ---------- flush and in_valid together in IDLE ----------
      @(negedge sysclk);
      base = ks_ptr;
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      #1;
      chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge sysclk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush_idle_state", {30'd0, dbg_state}, 32'd0);
      @(negedge sysclk);
      chk("flush_idle_steps", {24'd0, 8'(ks_ptr - base)}, 32'd0);

      // ---------- flush after three steps ----------
      ks_stream = '1;
      @(negedge sysclk);
      base = ks_ptr;
      in_valid = 1'b1; in_data = 8'h00; in_dir = 1'b0; in_feed = 1'b1;
      repeat (4) begin
         @(negedge sysclk);
         in_valid = 1'b0;
      end
      flush = 1'b1;
      #1;
      chk("flush_step_gated", {30'd0, ks_step, ks_feed}, 32'd0);
      @(negedge sysclk);
      flush = 1'b0;
      #1;
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_cleared", {22'd0, out_valid, out_data, out_par, out_par_err}, 32'd0);
      seen_valid = 1'b0;
      repeat (15) begin
         @(negedge sysclk);
         if (out_valid) seen_valid = 1'b1;
      end
      chk("flush_no_valid", {31'd0, seen_valid}, 32'd0);
      chk("flush_steps", {24'd0, 8'(ks_ptr - base)}, 32'd3);

      // ---------- asynchronous reset mid-SHIFT ----------
      @(negedge sysclk);
      in_valid = 1'b1; in_data = 8'h00; in_feed = 1'b1;
      repeat (4) begin
         @(negedge sysclk);
         in_valid = 1'b0;
      end
      resetn = 1'b0;
      #1;
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_outputs", {20'd0, out_valid, out_data, out_par, out_par_err, ks_step, ks_feed},
          32'd0);
      chk("arst_state", {30'd0, dbg_state}, 32'd0);
      @(negedge sysclk);
      resetn = 1'b1;
      in_feed = 1'b0;

      // one clean byte after the reset
      ks_stream = '0;
      run_byte(8'h81, 1'b0, 1'b0, 1'b0, 2, a_data, a_par, a_err, a_feed);
      chk("post_rst_data", {24'd0, a_data}, 32'h81);

      chk("feed_without_step", feed_viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/m1_byte_cipher.md
# m1_byte_cipher

Byte-level cipher sequencer that sits directly downstream of the Crypto1 keystream core and drives it. For each accepted byte it issues eight single-bit step requests to the core, XORs each data bit with the current keystream bit, and then produces the encrypted (or checked) ISO14443A odd-parity bit from the keystream bit that follows the byte. It optionally feeds plaintext bits back into the core's LFSR input, which is needed for reader-nonce injection during authentication.

## Interface
- No parameters. Byte width 8 and bit order LSB-first are fixed.
- sysclk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort: drop the current byte and return to IDLE
- in_valid  in  1  input byte offered
- in_ready  out  1  block can accept a byte (IDLE only, and flush=0)
- in_data  in  8  plaintext (encrypt) or ciphertext (decrypt)
- in_par  in  1  received encrypted parity bit; decrypt only
- in_dir  in  1  0 = encrypt, 1 = decrypt
- in_feed  in  1  1 = feed the plaintext bit into the core LFSR input on each step
- out_valid  out  1  result byte available
- out_ready  in  1  downstream accepts the result
- out_data  out  8  ciphertext (encrypt) or plaintext (decrypt)
- out_par  out  1  encrypted parity (encrypt) or decrypted parity (decrypt)
- out_par_err  out  1  decrypt only: decrypted parity is not the odd parity of out_data; 0 in encrypt
- ks_in  in  1  core's combinational filter output for its current LFSR state, before the next step
- ks_step  out  1  one-cycle step request to the core; the LFSR shifts at the end of that cycle
- ks_feed  out  1  bit XORed into the core feedback on a step; 0 whenever in_feed=0 or ks_step=0

## Operation
- States: IDLE, SHIFT, PAR, OUT.
- IDLE
  - in_ready=1 unless flush=1.
  - On in_valid&&in_ready: latch data, par, dir and feed into registers; clear bit counter k; go to SHIFT.
- SHIFT (k = 0..7)
  - ks_step=1.
  - Keystream bit is ks = ks_in.
  - Plaintext bit p: encrypt p = d[k]; decrypt p = d[k]^ks.
  - Result bit r[k] = d[k]^ks.
  - ks_feed = feed ? p : 0.
  - k increments each cycle; after k=7 go to PAR.
- PAR
  - ks_step=0, so the core does not shift.
  - Sample ks = ks_in, the keystream bit for the next byte's bit 0.
  - Let op = ~^plaintext, the odd-parity bit.
  - Encrypt: out_par = op^ks.
  - Decrypt: out_par = in_par^ks; out_par_err = out_par!=op.
  - Go to OUT.
- OUT
  - out_valid=1; out_data, out_par and out_par_err are held stable.
  - On out_ready: go to IDLE.
- flush in any state: next state is IDLE; out_valid drops; result registers are cleared; no further ks_step.
  - Core steps already issued are not undone.
  - flush outranks both in_valid and out_ready in the same cycle.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_par=0, out_par_err=0, ks_step=0, ks_feed=0.
- Accept at cycle T; ks_step high for T+1..T+8; PAR at T+9; out_valid rises at T+10.
- Minimum issue interval is 11 cycles per byte: OUT→IDLE takes one cycle, and there is no accept during OUT.
- ks_step and ks_feed are combinational from the state and the latched byte; ks_in is sampled in the same cycle.
- Result registers update only in SHIFT and PAR. In OUT they hold indefinitely under backpressure, and ks_step stays 0 there.
- Asynchronous reset mid-byte returns to IDLE immediately; the partial byte is lost.

## Structure
- Shared package m1_pkg:
  - state typedef (IDLE/SHIFT/PAR/OUT);
  - direction constants M1_ENC=0, M1_DEC=1;
  - odd-parity function.
- No sub-module; single flat FSM plus datapath.
- The Crypto1 core is instantiated beside this block at the next level up: ks_step → core start, ks_feed → core ser_in, core filter output → ks_in.

## Test plan
- Encrypt with ks_in tied 0: 0x00 → out_data 0x00, out_par 1; 0x01 → 0x01, out_par 0.
- Encrypt with ks_in tied 1: 0x00 → out_data 0xFF, out_par 0; exactly 8 ks_step pulses per byte; out_valid at T+10.
- Feed encrypt: 0xA5 with in_feed=1 and ks_in=0 → ks_feed sequence 1,0,1,0,0,1,0,1 on steps 0..7. With in_feed=0 → ks_feed stays 0.
- Decrypt with ks_in=1:
  - in_data 0x5A, in_par 1 → out_data 0xA5, out_par 0, out_par_err 1;
  - in_par 0 → out_par 1, out_par_err 0.
- Backpressure: hold out_ready=0 for 20 cycles → outputs stable, in_ready=0, no ks_step. Release → IDLE next cycle.
- Abort: flush asserted after 3 steps → exactly 3 ks_step pulses total, out_valid never rises, in_ready=1 next cycle. Asynchronous reset mid-SHIFT → all outputs take their reset values.
